// File: rtl/dbg_mem_arbiter.sv
// Shares the data-memory port between the CPU and the debug controller.
// A debug access stalls the CPU, waits for its outstanding reads, then takes the port for one access.
module dbg_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_valid,
    input  logic              dbg_rd,
    input  logic              dbg_wr,
    input  logic [3:0]        dbg_be,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_busy,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        ACCESS  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state;
    state_t              state_nxt;
    logic [MEM_LAT-1:0]  trk;
    logic                trk_empty;
    logic                cpu_rd_issue;
    logic                dbg_req_ok;
    logic                cnt_last;
    logic [CNT_W-1:0]    cnt;
    logic                req_rd;
    logic [3:0]          req_be;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;

    // Exactly one of rd/wr must be set for a request to be accepted.
    assign dbg_req_ok   = dbg_valid & (dbg_rd ^ dbg_wr);
    assign cpu_rd_issue = (state == IDLE) & cpu_rd;
    assign trk_empty    = (trk == '0);
    assign cnt_last     = (cnt == CNT_ONE);
    assign cpu_rdata    = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dbg_req_ok) state_nxt = DRAIN;
            DRAIN:   if (trk_empty) state_nxt = ACCESS;
            ACCESS:  state_nxt = req_rd ? RD_WAIT : IDLE;
            RD_WAIT: if (cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst gates the strobes directly so the pass-through path is silent during reset.
    always_comb begin
        dbg_busy  = (state != IDLE);
        cpu_stall = (state != IDLE);
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                mem_rd    = cpu_rd & ~rst;
                mem_wr    = cpu_wr & ~rst;
                mem_be    = cpu_be;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            ACCESS: begin
                mem_rd    = req_rd;
                mem_wr    = ~req_rd;
                mem_be    = req_be;
                mem_addr  = req_addr;
                mem_wdata = req_wdata;
            end
            default: ;
        endcase
    end

    // One bit per cycle of read latency; a set bit is a CPU read whose data is still due.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk <= '0;
        end else begin
            trk <= (trk << 1) | MEM_LAT'(cpu_rd_issue);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ACCESS && req_rd) begin
            cnt <= CNT_LOAD;
        end else if (state == RD_WAIT) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata <= '0;
        end else if (state == RD_WAIT && cnt_last) begin
            dbg_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_rd <= 1'b0;
        end else if (state == IDLE && dbg_req_ok) begin
            req_rd <= dbg_rd;
        end
    end

    // Request payload is only consumed after req_rd is latched, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && dbg_req_ok) begin
            req_be    <= dbg_be;
            req_addr  <= dbg_addr;
            req_wdata <= dbg_wdata;
        end
    end

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Directed bench for dbg_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=2,
// each with a small behavioural memory.
module tb_dbg_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // MEM_LAT=2 instance signals
    logic        dbg_valid, dbg_rd, dbg_wr;
    logic [3:0]  dbg_be;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_busy;
    logic        cpu_rd, cpu_wr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        m2_rd, m2_wr;
    logic [3:0]  m2_be;
    logic [31:0] m2_addr, m2_wdata, m2_rdata;

    // MEM_LAT=1 instance signals
    logic        d1_valid, d1_rd, d1_wr;
    logic [3:0]  d1_be;
    logic [31:0] d1_addr, d1_wdata, r1_rdata;
    logic        r1_busy, r1_stall;
    logic [31:0] r1_cpu_rdata;
    logic        m1_rd, m1_wr;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;

    // Preload port and event counters
    logic        pl_en;
    logic [31:0] pl_addr, pl_data;
    logic        cnt_clr;
    int          n_rd2, n_w200, n_w204;

    dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_wr(dbg_wr), .dbg_be(dbg_be),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_rd(m2_rd), .mem_wr(m2_wr), .mem_be(m2_be), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata)
    );

    dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_l1 (
        .clk(clk), .rst(rst),
        .dbg_valid(d1_valid), .dbg_rd(d1_rd), .dbg_wr(d1_wr), .dbg_be(d1_be),
        .dbg_addr(d1_addr), .dbg_wdata(d1_wdata), .dbg_rdata(r1_rdata), .dbg_busy(r1_busy),
        .cpu_rd(1'b0), .cpu_wr(1'b0), .cpu_be(4'h0), .cpu_addr(32'h0),
        .cpu_wdata(32'h0), .cpu_rdata(r1_cpu_rdata), .cpu_stall(r1_stall),
        .mem_rd(m1_rd), .mem_wr(m1_wr), .mem_be(m1_be), .mem_addr(m1_addr),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
    );

    logic [31:0] mem2 [0:255];
    logic [31:0] mem1 [0:255];
    logic [31:0] rp2_0, rp2_1, rp1_0;
    assign m2_rdata = rp2_1;
    assign m1_rdata = rp1_0;

    always_ff @(posedge clk) begin
        if (pl_en) begin
            mem2[pl_addr[9:2]] <= pl_data;
            mem1[pl_addr[9:2]] <= pl_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (m2_wr && m2_be[b]) mem2[m2_addr[9:2]][8*b +: 8] <= m2_wdata[8*b +: 8];
                if (m1_wr && m1_be[b]) mem1[m1_addr[9:2]][8*b +: 8] <= m1_wdata[8*b +: 8];
            end
        end
        rp2_0 <= m2_rd ? mem2[m2_addr[9:2]] : 32'h0;
        rp2_1 <= rp2_0;
        rp1_0 <= m1_rd ? mem1[m1_addr[9:2]] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            n_rd2  <= 0;
            n_w200 <= 0;
            n_w204 <= 0;
        end else begin
            if (m2_rd) n_rd2 <= n_rd2 + 1;
            if (m2_wr && m2_addr == 32'h200) n_w200 <= n_w200 + 1;
            if (m2_wr && m2_addr == 32'h204) n_w204 <= n_w204 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [31:0] pl_a [0:3];
    logic [31:0] pl_d [0:3];
    bit          found;

    initial begin
        pl_a[0] = 32'h104; pl_d[0] = 32'h12345678;
        pl_a[1] = 32'h040; pl_d[1] = 32'hCAFEF00D;
        pl_a[2] = 32'h080; pl_d[2] = 32'h0BADC0DE;
        pl_a[3] = 32'h010; pl_d[3] = 32'h55AA1234;

        rst = 1'b0;
        dbg_valid = 0; dbg_rd = 0; dbg_wr = 0; dbg_be = 4'h0; dbg_addr = 0; dbg_wdata = 0;
        d1_valid = 0; d1_rd = 0; d1_wr = 0; d1_be = 4'h0; d1_addr = 0; d1_wdata = 0;
        cpu_rd = 0; cpu_wr = 0; cpu_be = 4'h0; cpu_addr = 0; cpu_wdata = 0;
        pl_en = 0; pl_addr = 0; pl_data = 0; cnt_clr = 1;

        // Reset with a CPU read pending: strobes must stay low
        #2 rst = 1'b1;
        cpu_rd = 1; cpu_be = 4'hF; cpu_addr = 32'h40; cpu_wr = 1;
        smp();
        chk("rst_busy", dbg_busy, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_rd", m2_rd, 0);
        chk("rst_mem_wr", m2_wr, 0);
        chk("rst_rdata", dbg_rdata, 0);
        chk("rst_l1_busy", r1_busy, 0);
        cpu_rd = 0; cpu_wr = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            pl_en = 1; pl_addr = pl_a[i]; pl_data = pl_d[i];
        end
        cyc();
        pl_en = 0; rst = 1'b0; cnt_clr = 0;
        cyc();

        // Test 1: MEM_LAT=1 debug write
        cyc();
        d1_valid = 1; d1_wr = 1; d1_be = 4'hF; d1_addr = 32'h100; d1_wdata = 32'hDEADBEEF;
        smp();
        chk("t1_c0_busy", r1_busy, 0);
        chk("t1_c0_wr", m1_wr, 0);
        cyc();
        d1_valid = 0; d1_wr = 0;
        smp();
        chk("t1_c1_busy", r1_busy, 1);
        chk("t1_c1_wr", m1_wr, 0);
        cyc();
        smp();
        chk("t1_c2_busy", r1_busy, 1);
        chk("t1_c2_wr", m1_wr, 1);
        chk("t1_c2_addr", m1_addr, 32'h100);
        chk("t1_c2_data", m1_wdata, 32'hDEADBEEF);
        chk("t1_c2_be", m1_be, 4'hF);
        cyc();
        smp();
        chk("t1_c3_busy", r1_busy, 0);
        chk("t1_c3_wr", m1_wr, 0);
        chk("t1_mem", mem1[8'h40], 32'hDEADBEEF);

        // Test 1b: MEM_LAT=1 debug read of 0x10
        cyc();
        d1_valid = 1; d1_rd = 1; d1_addr = 32'h10;
        cyc();
        d1_valid = 0; d1_rd = 0;
        cyc();
        smp();
        chk("t1b_c2_rd", m1_rd, 1);
        chk("t1b_c2_addr", m1_addr, 32'h10);
        cyc();
        smp();
        chk("t1b_c3_busy", r1_busy, 1);
        cyc();
        smp();
        chk("t1b_c4_busy", r1_busy, 0);
        chk("t1b_rdata", r1_rdata, 32'h55AA1234);

        // Test 2: MEM_LAT=2 debug read of 0x104
        cyc();
        dbg_valid = 1; dbg_rd = 1; dbg_addr = 32'h104; dbg_be = 4'hF;
        smp();
        chk("t2_c0_busy", dbg_busy, 0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            dbg_valid = 0; dbg_rd = 0;
            smp();
            chk($sformatf("t2_c%0d_busy", c), dbg_busy, (c <= 4) ? 1'b1 : 1'b0);
            chk($sformatf("t2_c%0d_rd", c), m2_rd, (c == 2) ? 1'b1 : 1'b0);
            if (c == 2) chk("t2_c2_addr", m2_addr, 32'h104);
        end
        chk("t2_rdata", dbg_rdata, 32'h12345678);

        // Test 3: CPU read and debug read collide
        cyc();
        cpu_rd = 1; cpu_addr = 32'h40; cpu_be = 4'hF;
        dbg_valid = 1; dbg_rd = 1; dbg_addr = 32'h80;
        smp();
        chk("t3_c0_rd", m2_rd, 1);
        chk("t3_c0_addr", m2_addr, 32'h40);
        cyc();
        cpu_rd = 0; dbg_valid = 0; dbg_rd = 0;
        smp();
        chk("t3_c1_rd", m2_rd, 0);
        chk("t3_c1_stall", cpu_stall, 1);
        cyc();
        smp();
        chk("t3_c2_rd", m2_rd, 0);
        chk("t3_c2_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
        found = 0;
        for (int c = 3; c <= 8; c++) begin
            if (!found) begin
                cyc();
                smp();
                if (m2_rd) begin
                    found = 1;
                    chk("t3_dbg_addr", m2_addr, 32'h80);
                end
            end
        end
        chk("t3_dbg_rd_seen", found, 1);
        for (int c = 0; c < 8; c++) begin
            if (dbg_busy) begin
                cyc();
                smp();
            end
        end
        chk("t3_busy_end", dbg_busy, 0);
        chk("t3_rdata", dbg_rdata, 32'h0BADC0DE);

        // Test 4: CPU write held through a debug write
        cyc();
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        dbg_valid = 1; dbg_wr = 1; dbg_addr = 32'h204; dbg_wdata = 32'h11223344; dbg_be = 4'hF;
        cyc();
        dbg_valid = 0; dbg_wr = 0;
        cpu_wr = 1; cpu_addr = 32'h200; cpu_wdata = 32'hA5A5A5A5; cpu_be = 4'hF;
        smp();
        chk("t4_c1_stall", cpu_stall, 1);
        chk("t4_c1_wr", m2_wr, 0);
        cyc();
        smp();
        chk("t4_c2_wr", m2_wr, 1);
        chk("t4_c2_addr", m2_addr, 32'h204);
        cyc();
        smp();
        chk("t4_c3_stall", cpu_stall, 0);
        chk("t4_c3_wr", m2_wr, 1);
        chk("t4_c3_addr", m2_addr, 32'h200);
        chk("t4_c3_data", m2_wdata, 32'hA5A5A5A5);
        cyc();
        cpu_wr = 0;
        cyc();
        smp();
        chk("t4_n200", n_w200, 1);
        chk("t4_n204", n_w204, 1);
        chk("t4_mem200", mem2[8'h80], 32'hA5A5A5A5);
        chk("t4_mem204", mem2[8'h81], 32'h11223344);

        // Test 5: reset during RD_WAIT
        cyc();
        dbg_valid = 1; dbg_rd = 1; dbg_addr = 32'h104;
        cyc();
        dbg_valid = 0; dbg_rd = 0;
        cyc();
        cyc();
        smp();
        chk("t5_pre_busy", dbg_busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", dbg_busy, 0);
        chk("t5_stall", cpu_stall, 0);
        chk("t5_rdata", dbg_rdata, 0);
        chk("t5_rd", m2_rd, 0);
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk($sformatf("t5_post%0d_rdwr", c), {m2_rd, m2_wr, dbg_busy}, 3'b000);
            cyc();
        end

        // Test 6: malformed requests, then held dbg_rd
        dbg_valid = 1; dbg_rd = 1; dbg_wr = 1; dbg_addr = 32'h104;
        smp();
        chk("t6_both_busy0", dbg_busy, 0);
        cyc();
        dbg_rd = 0; dbg_wr = 0;
        smp();
        chk("t6_both_busy1", dbg_busy, 0);
        cyc();
        dbg_valid = 0;
        cnt_clr = 1;
        smp();
        chk("t6_none_busy", dbg_busy, 0);
        cyc();
        cnt_clr = 0;
        dbg_valid = 1; dbg_rd = 1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            dbg_valid = (c == 2);
            dbg_rd = (c < 6);
        end
        smp();
        chk("t6_n_rd", n_rd2, 1);
        chk("t6_busy", dbg_busy, 0);
        chk("t6_rdata", dbg_rdata, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
